// File: rtl/proc_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_mem_ctrl_pkg
//  Description : Shared opcode constants and the controller state encoding.
//                Imported by the controller RTL and by its testbench.
//                The CP_* states exist only when PROC_MEM_CTRL_COPY_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
package proc_mem_ctrl_pkg;

    // Request opcodes
    localparam logic [1:0] c_op_read  = 2'b00;
    localparam logic [1:0] c_op_write = 2'b01;
    localparam logic [1:0] c_op_copy  = 2'b10;
    localparam logic [1:0] c_op_rsvd  = 2'b11;

    // Controller states, explicitly encoded
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_ISSUE = 4'd1,
        RD_WAIT  = 4'd2,
        RD_CAP   = 4'd3,
        WR_ISSUE = 4'd4,
`ifdef PROC_MEM_CTRL_COPY_EN
        CP_RD    = 4'd5,
        CP_WAIT  = 4'd6,
        CP_WR    = 4'd7,
`endif
        DONE     = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/proc_mem_ctrl_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : proc_mem_ctrl_cnt
//  Description : Copy bookkeeping: loadable word down-counter with zero flag
//                plus source/destination address incrementers. All
//                arithmetic wraps modulo 2^ADR_BITS.
//  Ports       : clk, rst_n          clock, async active-low reset
//                load               load len/src/dst (has priority)
//                step               count down one word, advance addresses
//                len_in/src_in/dst_in  values loaded on load
//                zero               remaining count is zero
//                src/dst            current source/destination address
//  Revision    : 1.0  initial release
// ============================================================================
module proc_mem_ctrl_cnt #(
    parameter int ADR_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [ADR_BITS-1:0] len_in,
    input  logic [ADR_BITS-1:0] src_in,
    input  logic [ADR_BITS-1:0] dst_in,
    output logic                zero,
    output logic [ADR_BITS-1:0] src,
    output logic [ADR_BITS-1:0] dst
);

    logic [ADR_BITS-1:0] r_cnt;
    logic [ADR_BITS-1:0] r_src;
    logic [ADR_BITS-1:0] r_dst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_src <= '0;
            r_dst <= '0;
        end else if (load) begin
            r_cnt <= len_in;
            r_src <= src_in;
            r_dst <= dst_in;
        end else if (step) begin
            r_cnt <= r_cnt - 1'b1;
            r_src <= r_src + 1'b1;
            r_dst <= r_dst + 1'b1;
        end
    end

    assign zero = (r_cnt == '0);
    assign src  = r_src;
    assign dst  = r_dst;

endmodule
`default_nettype wire

// File: rtl/proc_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : proc_mem_ctrl
//  Description : Single-request memory controller for a clocked RAM with a
//                1-cycle registered read. Executes READ, WRITE and (when
//                PROC_MEM_CTRL_COPY_EN is defined) word-by-word COPY; any
//                other opcode completes with rsp_err=1 and no RAM access.
//  Ports       : clk, rst_n                       clock, async active-low reset
//                req_valid/req_ready              request handshake
//                req_op/adr/dst/len/wdata         request fields
//                rsp_valid/rsp_rdata/rsp_err      one-cycle completion
//                busy                             controller not idle
//                mem_en/write/adr/wdata/rdata     RAM port (outputs registered)
//  Config      : PROC_MEM_CTRL_COPY_EN  compiles the COPY opcode in
//  Revision    : 1.0  initial release
// ============================================================================
module proc_mem_ctrl
    import proc_mem_ctrl_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int ADR_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ADR_BITS-1:0] req_adr,
    input  logic [ADR_BITS-1:0] req_dst,
    input  logic [ADR_BITS-1:0] req_len,
    input  logic [WIDTH-1:0]    req_wdata,
    output logic                rsp_valid,
    output logic [WIDTH-1:0]    rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic                mem_en,
    output logic                mem_write,
    output logic [ADR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_mem_en;
    logic                r_mem_write;
    logic [ADR_BITS-1:0] r_mem_adr;
    logic [WIDTH-1:0]    r_mem_wdata;
    logic [WIDTH-1:0]    r_rdata;
    logic                r_err;

    logic                w_mem_en_nxt;
    logic                w_mem_write_nxt;
    logic [ADR_BITS-1:0] w_mem_adr_nxt;
    logic [WIDTH-1:0]    w_mem_wdata_nxt;
    logic [WIDTH-1:0]    w_rdata_nxt;
    logic                w_err_nxt;

`ifdef PROC_MEM_CTRL_COPY_EN
    logic                w_cnt_load;
    logic                w_cnt_step;
    logic                w_cnt_zero;
    logic [ADR_BITS-1:0] w_cp_src;
    logic [ADR_BITS-1:0] w_cp_dst;

    proc_mem_ctrl_cnt #(
        .ADR_BITS (ADR_BITS)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_cnt_load),
        .step   (w_cnt_step),
        .len_in (req_len),
        .src_in (req_adr),
        .dst_in (req_dst),
        .zero   (w_cnt_zero),
        .src    (w_cp_src),
        .dst    (w_cp_dst)
    );
`else
    // Copy fields have no function in this build.
    logic w_unused_copy_ports;
    assign w_unused_copy_ports = ^{req_dst, req_len};
`endif

    // ------------------------------------------------------------------------
    // State and RAM-side registers. Every bus value is decided one cycle
    // ahead by the next-state logic, so the RAM only ever sees flops.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_adr   <= w_mem_adr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-register logic.
    // READ    : IDLE -> RD_ISSUE (bus read) -> RD_CAP (data captured) -> DONE
    // WRITE   : IDLE -> WR_ISSUE (bus write) -> DONE
    // reserved: IDLE -> RD_WAIT (no access) -> DONE
    // COPY    : IDLE -> CP_WR, then per word CP_RD -> CP_WAIT -> CP_WR.
    //           CP_WR decides whether another word remains; its first visit
    //           carries no write, which also gives len=0 its T+2 completion.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_en_nxt    = 1'b0;
        w_mem_write_nxt = 1'b0;
        w_mem_adr_nxt   = r_mem_adr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
        w_err_nxt       = r_err;
`ifdef PROC_MEM_CTRL_COPY_EN
        w_cnt_load      = 1'b0;
        w_cnt_step      = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_err_nxt = 1'b0;
                    case (req_op)
                        c_op_read: begin
                            w_mem_en_nxt  = 1'b1;
                            w_mem_adr_nxt = req_adr;
                            w_state_nxt   = RD_ISSUE;
                        end
                        c_op_write: begin
                            w_mem_en_nxt    = 1'b1;
                            w_mem_write_nxt = 1'b1;
                            w_mem_adr_nxt   = req_adr;
                            w_mem_wdata_nxt = req_wdata;
                            w_state_nxt     = WR_ISSUE;
                        end
`ifdef PROC_MEM_CTRL_COPY_EN
                        c_op_copy: begin
                            w_cnt_load  = 1'b1;
                            w_state_nxt = CP_WR;
                        end
`endif
                        default: begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = RD_WAIT;
                        end
                    endcase
                end
            end
            RD_ISSUE: w_state_nxt = RD_CAP;
            RD_CAP: begin
                // RAM output is valid the cycle after the read was on the bus.
                w_rdata_nxt = mem_rdata;
                w_state_nxt = DONE;
            end
            RD_WAIT:  w_state_nxt = DONE;
            WR_ISSUE: w_state_nxt = DONE;
`ifdef PROC_MEM_CTRL_COPY_EN
            CP_WR: begin
                if (w_cnt_zero) begin
                    w_state_nxt = DONE;
                end else begin
                    w_mem_en_nxt  = 1'b1;
                    w_mem_adr_nxt = w_cp_src;
                    w_state_nxt   = CP_RD;
                end
            end
            CP_RD: w_state_nxt = CP_WAIT;
            CP_WAIT: begin
                w_mem_en_nxt    = 1'b1;
                w_mem_write_nxt = 1'b1;
                w_mem_adr_nxt   = w_cp_dst;
                w_mem_wdata_nxt = mem_rdata;
                w_cnt_step      = 1'b1;
                w_state_nxt     = CP_WR;
            end
`endif
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rsp_valid = (r_state == DONE);
    assign rsp_err   = (r_state == DONE) && r_err;
    assign rsp_rdata = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_write = r_mem_write;
    assign mem_adr   = r_mem_adr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_proc_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_proc_mem_ctrl
//  Description : Self-checking bench for proc_mem_ctrl with a behavioural
//                1-cycle-read RAM. Table-driven single-word requests plus
//                hand-written copy, wrap, len=0 and mid-operation reset
//                sequences. Copy sequences follow PROC_MEM_CTRL_COPY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_proc_mem_ctrl;
    import proc_mem_ctrl_pkg::*;

    localparam int WIDTH    = 16;
    localparam int ADR_BITS = 16;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [ADR_BITS-1:0] req_adr;
    logic [ADR_BITS-1:0] req_dst;
    logic [ADR_BITS-1:0] req_len;
    logic [WIDTH-1:0]    req_wdata;
    logic                rsp_valid;
    logic [WIDTH-1:0]    rsp_rdata;
    logic                rsp_err;
    logic                busy;
    logic                mem_en;
    logic                mem_write;
    logic [ADR_BITS-1:0] mem_adr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH-1:0]    mem_rdata;

    proc_mem_ctrl #(
        .WIDTH    (WIDTH),
        .ADR_BITS (ADR_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_adr   (req_adr),
        .req_dst   (req_dst),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: 1-cycle registered read.
    logic [WIDTH-1:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_write) ram[mem_adr] <= mem_wdata;
            else           mem_rdata    <= ram[mem_adr];
        end
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int               k;
        logic             wr;
        logic [ADR_BITS-1:0] adr;
        logic [WIDTH-1:0] wd;
    } acc_t;
    acc_t acc_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_acc(input string name, input int idx, input logic wr,
                             input logic [15:0] adr, input logic [15:0] wd);
        if (idx >= acc_log.size()) begin
            checks++;
            failures++;
            $display("FAIL %s actual=missing expected=access %0d", name, idx);
        end else begin
            check({name, ".wr"},  {31'd0, acc_log[idx].wr}, {31'd0, wr});
            check({name, ".adr"}, {16'd0, acc_log[idx].adr}, {16'd0, adr});
            if (wr) check({name, ".wdata"}, {16'd0, acc_log[idx].wd}, {16'd0, wd});
        end
    endtask

    // Issues one request and follows it to rsp_valid (bounded). lat is the
    // cycle count from accept (T) to rsp_valid; -1 if it never came.
    task automatic do_req(input string name, input logic [1:0] op, input logic [15:0] adr,
                          input logic [15:0] dst, input logic [15:0] len, input logic [15:0] wdata,
                          output int lat, output logic [15:0] rdata, output logic err,
                          output int en_cnt);
        int guard;
        int ready_hi;
        lat      = -1;
        rdata    = '0;
        err      = 1'b0;
        en_cnt   = 0;
        ready_hi = 0;
        acc_log.delete();
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_adr   = adr;
        req_dst   = dst;
        req_len   = len;
        req_wdata = wdata;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (req_ready) ready_hi++;
            if (mem_en) begin
                en_cnt++;
                acc_log.push_back('{k, mem_write, mem_adr, mem_wdata});
            end
            if (rsp_valid) begin
                lat   = k;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout actual=no rsp_valid expected=rsp within 200 cycles", name);
        end
        check({name, ".ready_low_while_busy"}, ready_hi, 0);
        @(negedge clk);
        check({name, ".rsp_pulse_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
        check({name, ".err_low_after"}, {31'd0, rsp_err}, 32'd0);
        check({name, ".ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        check({name, ".others_zero"},
              {26'd0, rsp_valid, rsp_err, busy, mem_en, mem_write, 1'b0},
              32'd0);
        check({name, ".mem_adr"},   {16'd0, mem_adr},   32'd0);
        check({name, ".mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
        check({name, ".rsp_rdata"}, {16'd0, rsp_rdata}, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] adr;
        logic [15:0] wdata;
        int          exp_lat;
        logic        exp_err;
        logic [15:0] exp_rdata;
        int          exp_en;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          lat;
        int          en_cnt;
        logic [15:0] rdata;
        logic        err;
        int          bad;

        vecs[0] = '{"wr_0010",  c_op_write, 16'h0010, 16'hBEEF, 2, 1'b0, 16'h0000, 1};
        vecs[1] = '{"rd_0010",  c_op_read,  16'h0010, 16'h0000, 3, 1'b0, 16'hBEEF, 1};
        vecs[2] = '{"wr_0011",  c_op_write, 16'h0011, 16'h1234, 2, 1'b0, 16'hBEEF, 1};
        vecs[3] = '{"rd_0011",  c_op_read,  16'h0011, 16'h0000, 3, 1'b0, 16'h1234, 1};
        vecs[4] = '{"rsvd_op",  c_op_rsvd,  16'h0011, 16'hFFFF, 2, 1'b1, 16'h1234, 0};
        vecs[5] = '{"wr_ffff",  c_op_write, 16'hFFFF, 16'hA5A5, 2, 1'b0, 16'h1234, 1};
        vecs[6] = '{"rd_ffff",  c_op_read,  16'hFFFF, 16'h0000, 3, 1'b0, 16'hA5A5, 1};
        vecs[7] = '{"rd_0000",  c_op_read,  16'h0000, 16'h0000, 3, 1'b0, 16'h0000, 1};

        for (int a = 0; a < 65536; a++) ram[a] = '0;
        mem_rdata = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_adr   = '0;
        req_dst   = '0;
        req_len   = '0;
        req_wdata = '0;

        // Reset values before any clock edge.
        #3;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven single requests ----------------
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].name, vecs[i].op, vecs[i].adr, 16'h0, 16'h0, vecs[i].wdata,
                   lat, rdata, err, en_cnt);
            check({vecs[i].name, ".latency"}, lat, vecs[i].exp_lat);
            check({vecs[i].name, ".err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
            check({vecs[i].name, ".rdata"}, {16'd0, rdata}, {16'd0, vecs[i].exp_rdata});
            check({vecs[i].name, ".mem_en_cycles"}, en_cnt, vecs[i].exp_en);
            if (vecs[i].exp_en == 1) begin
                check_acc({vecs[i].name, ".acc"}, 0, vecs[i].op == c_op_write,
                          vecs[i].adr, vecs[i].wdata);
                if (acc_log.size() > 0) check({vecs[i].name, ".acc_cycle"}, acc_log[0].k, 1);
            end
        end

`ifdef PROC_MEM_CTRL_COPY_EN
        // ---------------- COPY 3 words ----------------
        do_req("pre10", c_op_write, 16'h0010, 0, 0, 16'h0001, lat, rdata, err, en_cnt);
        do_req("pre11", c_op_write, 16'h0011, 0, 0, 16'h0002, lat, rdata, err, en_cnt);
        do_req("pre12", c_op_write, 16'h0012, 0, 0, 16'h0003, lat, rdata, err, en_cnt);
        do_req("copy3", c_op_copy, 16'h0010, 16'h0100, 16'd3, 16'h0, lat, rdata, err, en_cnt);
        check("copy3.latency", lat, 11);
        check("copy3.err", {31'd0, err}, 32'd0);
        check("copy3.mem_en_cycles", en_cnt, 6);
        check_acc("copy3.a0", 0, 1'b0, 16'h0010, 16'h0);
        check_acc("copy3.a1", 1, 1'b1, 16'h0100, 16'h0001);
        check_acc("copy3.a2", 2, 1'b0, 16'h0011, 16'h0);
        check_acc("copy3.a3", 3, 1'b1, 16'h0101, 16'h0002);
        check_acc("copy3.a4", 4, 1'b0, 16'h0012, 16'h0);
        check_acc("copy3.a5", 5, 1'b1, 16'h0102, 16'h0003);
        check("copy3.ram100", {16'd0, ram[16'h0100]}, 32'h0001);
        check("copy3.ram101", {16'd0, ram[16'h0101]}, 32'h0002);
        check("copy3.ram102", {16'd0, ram[16'h0102]}, 32'h0003);

        // ---------------- COPY with address wrap ----------------
        // RAM[FFFF]=A5A5, RAM[0000]=0; word 1 re-reads the freshly written 0000.
        do_req("copyw", c_op_copy, 16'hFFFF, 16'h0000, 16'd2, 16'h0, lat, rdata, err, en_cnt);
        check("copyw.latency", lat, 8);
        check_acc("copyw.a0", 0, 1'b0, 16'hFFFF, 16'h0);
        check_acc("copyw.a1", 1, 1'b1, 16'h0000, 16'hA5A5);
        check_acc("copyw.a2", 2, 1'b0, 16'h0000, 16'h0);
        check_acc("copyw.a3", 3, 1'b1, 16'h0001, 16'hA5A5);

        // ---------------- COPY len=0 ----------------
        do_req("copy0", c_op_copy, 16'h0010, 16'h0300, 16'd0, 16'h0, lat, rdata, err, en_cnt);
        check("copy0.latency", lat, 2);
        check("copy0.err", {31'd0, err}, 32'd0);
        check("copy0.mem_en_cycles", en_cnt, 0);

        // ---------------- reset during word 1 of a 4-word copy ----------------
        do_req("pre20", c_op_write, 16'h0020, 0, 0, 16'h0011, lat, rdata, err, en_cnt);
        do_req("pre21", c_op_write, 16'h0021, 0, 0, 16'h0022, lat, rdata, err, en_cnt);
        do_req("pre22", c_op_write, 16'h0022, 0, 0, 16'h0033, lat, rdata, err, en_cnt);
        do_req("pre23", c_op_write, 16'h0023, 0, 0, 16'h0044, lat, rdata, err, en_cnt);
        req_valid = 1'b1;
        req_op    = c_op_copy;
        req_adr   = 16'h0020;
        req_dst   = 16'h0200;
        req_len   = 16'd4;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        // Now in cycle T+5: the read of word 1 is on the bus.
        check("rstcp.word1_read_on_bus", {31'd0, mem_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstcp.async_mem_en", {31'd0, mem_en}, 32'd0);
        check("rstcp.async_busy", {31'd0, busy}, 32'd0);
        check("rstcp.async_ready", {31'd0, req_ready}, 32'd1);
        check("rstcp.async_mem_adr", {16'd0, mem_adr}, 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_en || rsp_valid) bad++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (mem_en || rsp_valid) bad++;
        end
        check("rstcp.no_activity_after_abort", bad, 0);
        check("rstcp.ram200", {16'd0, ram[16'h0200]}, 32'h0011);
        check("rstcp.ram201", {16'd0, ram[16'h0201]}, 32'h0000);
        do_req("rstcp.read", c_op_read, 16'h0200, 0, 0, 0, lat, rdata, err, en_cnt);
        check("rstcp.read.latency", lat, 3);
        check("rstcp.read.rdata", {16'd0, rdata}, 32'h0011);
`else
        // ---------------- COPY compiled out: opcode 10 is reserved ----------------
        do_req("copyoff", c_op_copy, 16'h0010, 16'h0100, 16'd3, 16'h0, lat, rdata, err, en_cnt);
        check("copyoff.latency", lat, 2);
        check("copyoff.err", {31'd0, err}, 32'd1);
        check("copyoff.mem_en_cycles", en_cnt, 0);
        check("copyoff.ram100", {16'd0, ram[16'h0100]}, 32'h0000);

        // ---------------- reset during a READ ----------------
        req_valid = 1'b1;
        req_op    = c_op_read;
        req_adr   = 16'hFFFF;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstrd.read_on_bus", {31'd0, mem_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstrd.async_mem_en", {31'd0, mem_en}, 32'd0);
        check("rstrd.async_busy", {31'd0, busy}, 32'd0);
        check("rstrd.async_ready", {31'd0, req_ready}, 32'd1);
        check("rstrd.async_rdata", {16'd0, rsp_rdata}, 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_en || rsp_valid) bad++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (mem_en || rsp_valid) bad++;
        end
        check("rstrd.no_activity_after_abort", bad, 0);
        do_req("rstrd.read", c_op_read, 16'hFFFF, 0, 0, 0, lat, rdata, err, en_cnt);
        check("rstrd.read.latency", lat, 3);
        check("rstrd.read.rdata", {16'd0, rdata}, 32'hA5A5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proc_mem_ctrl.md
PROC_MEM_CTRL -- requirements
Module: proc_mem_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter ADR_BITS, default 16, RAM address width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid input 1 and req_ready output 1, the request handshake.
REQ-006 SHALL have port req_op  input  2  opcode: 00 READ, 01 WRITE, 10 COPY, 11 reserved.
REQ-007 SHALL have ports req_adr input ADR_BITS (address or copy source), req_dst input ADR_BITS (copy destination) and req_len input ADR_BITS (copy word count).
REQ-008 SHALL have port req_wdata  input  WIDTH  write data.
REQ-009 SHALL have ports rsp_valid output 1, rsp_rdata output WIDTH and rsp_err output 1, the completion response.
REQ-010 SHALL have port busy  output  1, high whenever state is not IDLE.
REQ-011 SHALL have RAM-side ports mem_en output 1, mem_write output 1, mem_adr output ADR_BITS, mem_wdata output WIDTH and mem_rdata input WIDTH, for a clocked RAM with 1-cycle registered read.

Function
REQ-012 SHALL set req_ready=1 only in IDLE; a request is accepted in cycle T when req_valid and req_ready are both 1, and all req_* fields are latched at the end of T.
REQ-013 SHALL implement the states IDLE, RD_ISSUE, RD_WAIT, RD_CAP, WR_ISSUE, CP_RD, CP_WAIT, CP_WR and DONE.
REQ-014 SHALL drive all RAM outputs from registers only.
REQ-015 SHALL hold mem_en=0 and mem_write=0 in every cycle except an access cycle; mem_adr and mem_wdata hold their last values otherwise.
REQ-016 READ: mem_en=1 and mem_write=0 with mem_adr=req_adr in T+1; mem_rdata is captured at the end of T+2; rsp_valid=1 with rsp_rdata in T+3.
REQ-017 WRITE: mem_en=1, mem_write=1, mem_adr=req_adr and mem_wdata=req_wdata in T+1; rsp_valid=1 in T+2.
REQ-018 COPY: for i = 0..len-1 in ascending order, each word takes 3 cycles:
  - CP_RD: read of src+i issued;
  - CP_WAIT: mem_rdata loaded into mem_wdata;
  - CP_WR: write of dst+i.
REQ-019 COPY: rsp_valid SHALL assert in the cycle after the last CP_WR, for a total latency of 3*len+2 cycles from T.
REQ-020 COPY with len=0 SHALL perform no RAM access and assert rsp_valid in T+2 with rsp_err=0.
REQ-021 Address arithmetic SHALL wrap modulo 2^ADR_BITS; src/dst overlap receives no special handling.
REQ-022 Reserved opcode SHALL perform no RAM access and assert rsp_valid in T+2 with rsp_err=1.
REQ-023 rsp_valid SHALL be a one-cycle pulse in DONE, with no back-pressure.
REQ-024 rsp_rdata SHALL hold its last read value until the next READ completes.
REQ-025 rsp_err SHALL be valid only while rsp_valid=1 and 0 otherwise.
REQ-026 The controller SHALL return to IDLE after DONE; the earliest next accept is in the cycle after rsp_valid.

Reset
REQ-027 While rst_n=0, all outputs SHALL be 0 except req_ready, which SHALL be 1, and state SHALL be IDLE, independent of clk.
REQ-028 Reset asserted mid-operation SHALL abort it immediately with no further RAM access and no rsp_valid; a partially completed copy is left as-is.

Configuration
REQ-029 SHALL use macro PROC_MEM_CTRL_COPY_EN to compile the COPY opcode in or out.
REQ-030 With PROC_MEM_CTRL_COPY_EN defined, COPY SHALL behave as in REQ-018 to REQ-020.
REQ-031 Without PROC_MEM_CTRL_COPY_EN, opcode 10 SHALL behave as reserved (REQ-022), the CP_* states and the length counter SHALL be absent, and req_dst and req_len SHALL be ignored.

Structure
REQ-032 SHALL place the opcode constants, the state enum typedef and the state encoding in package proc_mem_ctrl_pkg, shared with the bench.
REQ-033 SHALL use one sub-module, proc_mem_ctrl_cnt: a loadable ADR_BITS down-counter with a zero flag and src/dst incrementers, instantiated only under PROC_MEM_CTRL_COPY_EN.

Verification
REQ-034 Reset, then WRITE adr=0x0010, wdata=0xBEEF -> mem_write=1 at adr 0x0010 in T+1, rsp_valid in T+2, rsp_err=0.
REQ-035 READ adr=0x0010 after REQ-034 -> rsp_valid in T+3 with rsp_rdata=0xBEEF; req_ready=0 during T+1..T+3.
REQ-036 COPY src=0x0010, dst=0x0100, len=3 with RAM[0x10..0x12]={1,2,3} -> RAM[0x100..0x102]={1,2,3}; rsp_valid at T+11; mem_en high exactly 6 cycles.
REQ-037 COPY src=0xFFFF, dst=0x0000, len=2 -> reads 0xFFFF then 0x0000, writes 0x0000 then 0x0001 (wrap).
REQ-038 COPY len=0 and op=11 -> no mem_en; rsp_valid at T+2 with rsp_err=0 and 1 respectively; build without PROC_MEM_CTRL_COPY_EN -> op=10 returns rsp_err=1.
REQ-039 Assert rst_n=0 during the 2nd word of a len=4 copy -> outputs cleared asynchronously, no rsp_valid, only word 0 written; a READ after release works.
